// File: rtl/crc16_frame_ctrl.sv
// crc16_frame_ctrl: frame sequencer in front of an external 8-bit parallel
// CRC-16 byte stage.
//
// The block passes a delimited byte stream through to its output. Every
// accepted byte is also presented to the byte stage, together with the running
// CRC. With APPEND=1 the final CRC goes out as two extra bytes, high byte first.
//
// The byte stage result comes back registered, one clock later, on crc_result.
// A bypass lets a byte be accepted on every clock: on the clock after a beat,
// the running CRC is taken straight from crc_result.
//
// Optional build macro: CRC_CHECK_EN
//   When defined, the appended CRC bytes are also fed to the byte stage. The
//   CRC that results is compared against CHECK_RESIDUE, and crc_err pulses
//   together with crc_done on a mismatch. With APPEND=1 the crc_done and
//   crc_err pulses therefore come one clock later than in the default build,
//   because the residue only arrives after the low CRC byte.
//   When undefined, crc_err is tied low.
module crc16_frame_ctrl #(
  parameter logic [15:0] SEED          = 16'hFFFF,
  parameter logic [15:0] XOR_OUT       = 16'h0000,
  parameter bit          APPEND        = 1'b1,
  parameter logic [15:0] CHECK_RESIDUE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic [7:0]  crc_byte,
  output logic [15:0] crc_state,
  input  logic [15:0] crc_result,
  output logic [15:0] crc_final,
  output logic        crc_done,
  output logic        crc_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    CRC_HI = 3'd2,
    CRC_LO = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  logic        pending;     // byte stage result on crc_result belongs to this frame
  logic        hi_entry;    // first clock in CRC_HI: final CRC only visible via bypass
  logic [15:0] crc_reg;
  logic [15:0] crc_hold;
  logic [15:0] fin;
  logic        s_beat;
  logic        stage_beat;  // a byte is handed to the byte stage this clock

`ifdef CRC_CHECK_EN
  logic        chk_pending; // residue of the appended bytes arrives this clock
`endif

  // Output steering, byte-stage feed and running-CRC bypass
  always_comb begin
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_data     = 8'h00;
    m_last     = 1'b0;
    crc_byte   = 8'h00;
    // In IDLE the result from the previous frame's last byte is ignored.
    crc_state  = (state == IDLE || !pending) ? crc_reg : crc_result;
    fin        = crc_state ^ XOR_OUT;
    case (state)
      IDLE, DATA: begin
        s_ready = m_ready;
        m_valid = s_valid;
        m_data  = s_data;
        m_last  = APPEND ? 1'b0 : s_last;
        if (s_valid && m_ready) crc_byte = s_data;
      end
      CRC_HI: begin
        m_valid = 1'b1;
        m_data  = hi_entry ? fin[15:8] : crc_hold[15:8];
      end
      CRC_LO: begin
        m_valid = 1'b1;
        m_data  = crc_hold[7:0];
        m_last  = 1'b1;
      end
      default: ;
    endcase
    stage_beat = s_valid && s_ready;
`ifdef CRC_CHECK_EN
    // The appended CRC bytes keep running through the byte stage.
    if ((state == CRC_HI || state == CRC_LO) && m_ready) begin
      crc_byte   = m_data;
      stage_beat = 1'b1;
    end
`endif
  end

  assign s_beat = s_valid && s_ready;

`ifndef CRC_CHECK_EN
  // No residue checker in this build: constant-zero error flag.
  assign crc_err = |(CHECK_RESIDUE & 16'h0000);
`endif

  // Frame FSM, running CRC register and completion pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      crc_reg   <= SEED;
      pending   <= 1'b0;
      hi_entry  <= 1'b0;
      crc_final <= 16'h0000;
      crc_done  <= 1'b0;
`ifdef CRC_CHECK_EN
      crc_err     <= 1'b0;
      chk_pending <= 1'b0;
`endif
    end else begin
      crc_done <= 1'b0;
      hi_entry <= 1'b0;
      pending  <= stage_beat;
`ifdef CRC_CHECK_EN
      crc_err     <= 1'b0;
      chk_pending <= 1'b0;
`endif
      if (pending && state != IDLE) crc_reg <= crc_state;
      case (state)
        IDLE: begin
          crc_reg  <= SEED;
          hi_entry <= s_beat && s_last && APPEND;
          if (s_beat) begin
            if (s_last) state <= APPEND ? CRC_HI : DONE;
            else        state <= DATA;
          end
        end
        DATA: begin
          if (s_beat && s_last) begin
            if (APPEND) begin
              state    <= CRC_HI;
              hi_entry <= 1'b1;
            end else begin
              state <= DONE;
            end
          end
        end
        CRC_HI: begin
          if (m_ready) state <= CRC_LO;
        end
        CRC_LO: begin
          if (m_ready) begin
            state   <= IDLE;
            crc_reg <= SEED;
`ifdef CRC_CHECK_EN
            chk_pending <= 1'b1;
`else
            crc_final <= crc_hold;
            crc_done  <= 1'b1;
`endif
          end
        end
        DONE: begin
          state     <= IDLE;
          crc_reg   <= SEED;
          crc_final <= fin;
          crc_done  <= 1'b1;
`ifdef CRC_CHECK_EN
          crc_err <= (crc_state != CHECK_RESIDUE);
`endif
        end
        default: state <= IDLE;
      endcase
`ifdef CRC_CHECK_EN
      if (chk_pending) begin
        crc_final <= crc_hold;
        crc_done  <= 1'b1;
        crc_err   <= (crc_result != CHECK_RESIDUE);
      end
`endif
    end
  end

  // Final CRC snapshot so stalled CRC bytes stay stable
  always_ff @(posedge clk) begin
    if (hi_entry) crc_hold <= fin;
  end

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// Testbench for crc16_frame_ctrl: emulates the external byte stage with an
// MSB-first CRC-16 (poly 0xBAAD), drives random frames and scores the output
// stream and completion results against a frame-level model.
module tb_crc16_frame_ctrl;

  localparam logic [15:0] POLY = 16'hBAAD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_last;
  logic [7:0]  crc_byte;
  logic [15:0] crc_state;
  logic [15:0] crc_result = 16'h0000;
  logic [15:0] crc_final;
  logic        crc_done;
  logic        crc_err;

  always #5 clk = ~clk;

  crc16_frame_ctrl #(.SEED(16'h0000), .XOR_OUT(16'h0000), .APPEND(1'b1),
                     .CHECK_RESIDUE(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .crc_byte(crc_byte), .crc_state(crc_state), .crc_result(crc_result),
    .crc_final(crc_final), .crc_done(crc_done), .crc_err(crc_err)
  );

  function automatic logic [15:0] stage(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] frame_crc(input logic [7:0] q[$]);
    logic [15:0] c;
    c = 16'h0000;
    foreach (q[i]) c = stage(c, q[i]);
    return c;
  endfunction

  // External byte stage: always computing, result registered.
  always @(posedge clk) crc_result <= stage(crc_state, crc_byte);

  typedef struct packed { logic [7:0] d; logic l; } beat_t;
  beat_t       exp_q[$];
  logic [15:0] fin_q[$];
  logic [7:0]  out_log[$];
  logic [7:0]  fq[$];
  logic [15:0] last_final = 16'h0000;
  int          nchk = 0;
  int          npass = 0;
  bit          rdy_rand = 1'b0;
  bit          rdy_force = 1'b1;
  bit          prev_done = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void fail(input string name);
    nchk++;
    $display("FAIL %s", name);
  endfunction

`ifdef CRC_CHECK_EN
  // Receive-side instance: sees exactly the beats the main instance accepts,
  // with APPEND=0 so the residue of data+CRC is checked.
  logic        c_s_valid, c_s_ready, c_m_valid, c_m_last, c_crc_done, c_crc_err;
  logic [7:0]  c_m_data, c_crc_byte;
  logic [15:0] c_crc_state, c_crc_final;
  logic [15:0] c_crc_result = 16'h0000;
  typedef struct packed { logic [15:0] f; logic e; } chk_t;
  chk_t        chk_q[$];
  logic [15:0] last_c_final = 16'h0000;
  logic        last_c_err = 1'b0;
  assign c_s_valid = s_valid & s_ready;

  crc16_frame_ctrl #(.SEED(16'h0000), .XOR_OUT(16'h0000), .APPEND(1'b0),
                     .CHECK_RESIDUE(16'h0000)) u_chk (
    .clk(clk), .reset(reset),
    .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(c_m_valid), .m_ready(m_ready), .m_data(c_m_data), .m_last(c_m_last),
    .crc_byte(c_crc_byte), .crc_state(c_crc_state), .crc_result(c_crc_result),
    .crc_final(c_crc_final), .crc_done(c_crc_done), .crc_err(c_crc_err)
  );

  always @(posedge clk) c_crc_result <= stage(c_crc_state, c_crc_byte);

  always @(negedge clk) begin
    if (!reset && c_crc_done) begin
      if (chk_q.size() == 0) fail("chk_spurious_done");
      else begin
        chk_t e;
        e = chk_q.pop_front();
        check("chk_crc_final", c_crc_final, e.f);
        check("chk_crc_err", c_crc_err, e.e);
        last_c_final = c_crc_final;
        last_c_err   = c_crc_err;
      end
    end
  end
`endif

  // Downstream ready: fixed by the sequence, or random.
  always @(posedge clk) begin
    #2;
    m_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Compare process: every output handshake and every completion pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) fail("extra_out_beat");
        else begin
          beat_t e;
          e = exp_q.pop_front();
          check("m_data", m_data, e.d);
          check("m_last", m_last, e.l);
          out_log.push_back(m_data);
        end
      end
      if (crc_done) begin
        if (prev_done) fail("crc_done_wider_than_1clk");
        if (fin_q.size() == 0) fail("spurious_crc_done");
        else begin
          check("crc_final", crc_final, fin_q.pop_front());
          check("crc_err", crc_err, 0);
          last_final = crc_final;
        end
      end
      prev_done = crc_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic drive_byte(input logic [7:0] b, input logic last, input bit gaps);
    int n;
    if (gaps) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_ready && n < 500);
    if (!s_ready) fail("accept_timeout");
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] q[$], input bit gaps);
    logic [15:0] c;
    c = frame_crc(q);
    foreach (q[i]) exp_q.push_back('{d: q[i], l: 1'b0});
    exp_q.push_back('{d: c[15:8], l: 1'b0});
    exp_q.push_back('{d: c[7:0], l: 1'b1});
    fin_q.push_back(c);
`ifdef CRC_CHECK_EN
    chk_q.push_back('{f: c, e: (c != 16'h0000)});
`endif
    foreach (q[i]) drive_byte(q[i], (i == q.size() - 1), gaps);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    int left;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      left = exp_q.size() + fin_q.size();
`ifdef CRC_CHECK_EN
      left += chk_q.size();
`endif
    end while (left != 0 && n < 2000);
    if (left != 0) fail("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic rand_frame(input int len);
    fq.delete();
    for (int i = 0; i < len; i++) fq.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [15:0] c;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_m_valid", m_valid, 0);
    check("reset_s_ready", s_ready, m_ready);
    check("reset_crc_done", crc_done, 0);
    check("reset_crc_final", crc_final, 16'h0000);
    check("reset_crc_state_seed", crc_state, 16'h0000);
    @(posedge clk); #1;

    // Single-byte frame
    fq = {8'h01};
    check("model_pin_01", frame_crc(fq), 16'hBAAD);
    out_log.delete();
    send_frame(fq, 1'b0);
    wait_idle();
    check("t1_len", out_log.size(), 3);
    if (out_log.size() == 3) begin
      check("t1_b0", out_log[0], 8'h01);
      check("t1_b1", out_log[1], 8'hBA);
      check("t1_b2", out_log[2], 8'hAD);
    end
    check("t1_final", last_final, 16'hBAAD);

    // All-zero frame
    fq = {8'h00, 8'h00, 8'h00};
    out_log.delete();
    send_frame(fq, 1'b0);
    wait_idle();
    check("t2_len", out_log.size(), 5);
    if (out_log.size() == 5) begin
      check("t2_crc_hi", out_log[3], 8'h00);
      check("t2_crc_lo", out_log[4], 8'h00);
    end
    check("t2_final", last_final, 16'h0000);

    // Stall in CRC_HI with a pending next byte on the input
    fq = {8'h12, 8'h34};
    c = frame_crc(fq);
    send_frame(fq, 1'b0);
    rdy_force = 1'b0;
    s_valid   = 1'b1;
    s_data    = 8'h55;
    repeat (5) begin
      @(negedge clk);
      check("stall_m_valid", m_valid, 1);
      check("stall_s_ready", s_ready, 0);
      check("stall_m_data", m_data, c[15:8]);
      check("stall_m_last", m_last, 0);
    end
    @(posedge clk); #1;
    s_valid   = 1'b0;
    rdy_force = 1'b1;
    wait_idle();
    check("t4_final", last_final, c);

    // 64 bytes at full rate, then 64 with random gaps and backpressure
    rand_frame(64);
    send_frame(fq, 1'b0);
    wait_idle();
    check("t3_full_final", last_final, frame_crc(fq));
    rand_frame(64);
    rdy_rand = 1'b1;
    send_frame(fq, 1'b1);
    wait_idle();
    check("t3_gap_final", last_final, frame_crc(fq));

    // Back-to-back frames of random length under backpressure
    for (int k = 0; k < 6; k++) begin
      rand_frame($urandom_range(1, 9));
      send_frame(fq, 1'b0);
    end
    wait_idle();
    rdy_rand = 1'b0;
    @(posedge clk); #1;

    // Reset after three bytes of a frame: nothing from that frame survives
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{d: 8'(8'hA0 + i), l: 1'b0});
      drive_byte(8'(8'hA0 + i), 1'b0, 1'b0);
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("abort_passthru_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(negedge clk);
    check("abort_crc_final", crc_final, 16'h0000);
    check("abort_crc_state", crc_state, 16'h0000);
    check("abort_crc_done", crc_done, 0);
    @(posedge clk); #1;
    fq = {8'h01};
    out_log.delete();
    send_frame(fq, 1'b0);
    wait_idle();
    check("t5_len", out_log.size(), 3);
    if (out_log.size() == 3) begin
      check("t5_b1", out_log[1], 8'hBA);
      check("t5_b2", out_log[2], 8'hAD);
    end
    check("t5_final", last_final, 16'hBAAD);

`ifdef CRC_CHECK_EN
    // Loopback of a correct codeword, then one with a flipped CRC bit
    fq = {8'h01, 8'hBA, 8'hAD};
    send_frame(fq, 1'b0);
    wait_idle();
    check("t6_good_err", last_c_err, 0);
    check("t6_good_residue", last_c_final, 16'h0000);
    fq = {8'h01, 8'hBA, 8'hAC};
    send_frame(fq, 1'b0);
    wait_idle();
    check("t6_bad_err", last_c_err, 1);
`endif

    check("leftover_out_beats", exp_q.size(), 0);
    check("leftover_crc_results", fin_q.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
